// File: rtl/trng_arbiter_if.sv
// -----------------------------------------------------------------------------
// trng_arbiter_if
// Bundles the TRNG-source handshake and the two-requester delivery bus of
// trng_arbiter.
//
// Signals:
//   trng_req     arbiter -> source     high while words are being collected
//   trng_word    source  -> arbiter    one entropy word (TRNG_WIDTH bits)
//   trng_valid   source  -> arbiter    trng_word valid this cycle
//   req0, req1   requester -> arbiter  level requests, held until acked
//   ack0, ack1   arbiter -> requester  one-cycle pulse, rdata valid alongside
//   rdata        arbiter -> requester  assembled random word (OUT_WIDTH bits)
//   health_fail  arbiter -> system     sticky health-test failure flag
//
// Modports:
//   slave  - the arbiter side
//   master - the environment side (TRNG source plus requesters)
// -----------------------------------------------------------------------------
interface trng_arbiter_if #(
  parameter int TRNG_WIDTH = 8,
  parameter int OUT_WIDTH  = 32
);
  logic                  trng_req;
  logic [TRNG_WIDTH-1:0] trng_word;
  logic                  trng_valid;
  logic                  req0;
  logic                  req1;
  logic                  ack0;
  logic                  ack1;
  logic [OUT_WIDTH-1:0]  rdata;
  logic                  health_fail;

  modport slave (
    output trng_req, ack0, ack1, rdata, health_fail,
    input  trng_word, trng_valid, req0, req1
  );

  modport master (
    input  trng_req, ack0, ack1, rdata, health_fail,
    output trng_word, trng_valid, req0, req1
  );
endinterface

// File: rtl/trng_arbiter.sv
// -----------------------------------------------------------------------------
// trng_arbiter
// Shares one TRNG source between two requesters. A granted requester gets
// OUT_WIDTH/TRNG_WIDTH consecutive accepted entropy words packed into one
// word (first word in the MSBs), delivered with a one-cycle ack. Grants are
// round-robin; after reset requester 0 is favoured.
//
// Optional feature (macro TRNG_HEALTH_EN): repetition-count health test.
// RCT_LIMIT consecutive identical accepted words raise the sticky
// health_fail flag and park the arbiter in FAIL until reset. Without the
// macro health_fail is tied low and no comparison logic exists.
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     trng_arbiter_if.slave (trng_req/trng_word/trng_valid,
//           req0/req1, ack0/ack1, rdata, health_fail)
// -----------------------------------------------------------------------------
module trng_arbiter #(
  parameter int TRNG_WIDTH = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int RCT_LIMIT  = 4
) (
  input  logic           clk,
  input  logic           resetn,
  trng_arbiter_if.slave  bus
);

  localparam int N     = OUT_WIDTH / TRNG_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = OUT_WIDTH - TRNG_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DELIVER = 2'd2;
  localparam logic [1:0] FAIL    = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic                 owner;
  logic                 prio;
  logic [CNT_W-1:0]     cnt;
  logic [SH_W-1:0]      shift;
  logic [OUT_WIDTH-1:0] shift_nx;
  logic [OUT_WIDTH-1:0] rdata_q;
  logic                 owner_req;
  logic                 accept;
  logic                 rct_trip;

  // Only the N-1 oldest words need storing; the Nth word completes the
  // result straight from the bus.
  assign shift_nx  = {shift, bus.trng_word};
  assign owner_req = owner ? bus.req1 : bus.req0;

  // A word counts only in COLLECT while the owner still wants it; an owner
  // dropping its request in the same cycle wins over the word.
  assign accept = (state == COLLECT) && owner_req && bus.trng_valid;

`ifdef TRNG_HEALTH_EN
  localparam int RCT_W = $clog2(RCT_LIMIT + 1);

  logic [RCT_W-1:0]      rep_cnt;
  logic [RCT_W-1:0]      rep_cnt_nx;
  logic [TRNG_WIDTH-1:0] last_word;
  logic                  fail_q;

  // Run length of identical accepted words; it spans request boundaries,
  // and rep_cnt==0 marks "no word seen yet" after reset.
  always_comb begin
    rep_cnt_nx = rep_cnt;
    if (accept) begin
      if ((rep_cnt != '0) && (bus.trng_word == last_word))
        rep_cnt_nx = rep_cnt + RCT_W'(1);
      else
        rep_cnt_nx = RCT_W'(1);
    end
  end

  assign rct_trip = accept && (rep_cnt_nx >= RCT_W'(RCT_LIMIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rep_cnt   <= '0;
      last_word <= '0;
      fail_q    <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt_nx;
      if (accept)
        last_word <= bus.trng_word;
      if (rct_trip)
        fail_q <= 1'b1;
    end
  end

  assign bus.health_fail = fail_q;
`else
  // Keeps RCT_LIMIT referenced in builds without the health test.
  localparam int unused_rct_limit = RCT_LIMIT;

  assign rct_trip        = 1'b0;
  assign bus.health_fail = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1)
          state_nx = COLLECT;
      end
      COLLECT: begin
        if (!owner_req)
          state_nx = IDLE;
        else if (rct_trip)
          state_nx = FAIL;
        else if (accept && (cnt == LAST_IDX))
          state_nx = DELIVER;
      end
      DELIVER: state_nx = IDLE;
      FAIL:    state_nx = FAIL;
      default: state_nx = IDLE;
    endcase
  end

  // prio=0 favours req0, prio=1 favours req1. It only moves on a real
  // delivery, so an abandoned collection leaves the fairness order alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      owner   <= 1'b0;
      prio    <= 1'b0;
      cnt     <= '0;
      shift   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner <= (bus.req0 && bus.req1) ? prio : bus.req1;
            cnt   <= '0;
            shift <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            shift <= shift_nx[SH_W-1:0];
            if (cnt != LAST_IDX)
              cnt <= cnt + CNT_W'(1);
            if (state_nx == DELIVER)
              rdata_q <= shift_nx;
          end
        end
        DELIVER: prio <= ~owner;
        default: ;
      endcase
    end
  end

  assign bus.trng_req = (state == COLLECT);
  assign bus.ack0     = (state == DELIVER) && !owner;
  assign bus.ack1     = (state == DELIVER) && owner;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_trng_arbiter.sv
// -----------------------------------------------------------------------------
// tb_trng_arbiter
// Self-checking bench for trng_arbiter: directed scenarios followed by a
// randomized request/entropy stream, all compared every cycle against a
// transaction-level reference model (a queue of collected words plus a
// round-robin preference bit).
// -----------------------------------------------------------------------------
module tb_trng_arbiter;

  localparam int TW    = 8;
  localparam int OW    = 32;
  localparam int N     = OW / TW;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  trng_arbiter_if #(.TRNG_WIDTH(TW), .OUT_WIDTH(OW)) bus ();

  trng_arbiter #(
    .TRNG_WIDTH (TW),
    .OUT_WIDTH  (OW),
    .RCT_LIMIT  (LIMIT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  bit            health_on;
  bit            m_collecting;
  bit            m_delivering;
  bit            m_failed;
  bit            m_owner;
  bit            m_prio;
  logic [TW-1:0] m_words[$];
  logic [OW-1:0] m_rdata;
  logic [TW-1:0] m_rep_word;
  int            m_rep_n;

  int ack_order[$];

  task automatic modelReset();
    m_collecting = 1'b0;
    m_delivering = 1'b0;
    m_failed     = 1'b0;
    m_owner      = 1'b0;
    m_prio       = 1'b0;
    m_words.delete();
    m_rdata      = '0;
    m_rep_word   = '0;
    m_rep_n      = 0;
  endtask

  // One clock edge of the reference behaviour, given the inputs present at it.
  task automatic modelStep(input bit r0, input bit r1, input bit v, input logic [TW-1:0] w);
    bit oreq;
    if (m_failed) return;
    if (m_delivering) begin
      m_delivering = 1'b0;
      m_prio       = (m_owner == 1'b0);
    end else if (m_collecting) begin
      oreq = m_owner ? r1 : r0;
      if (!oreq) begin
        m_collecting = 1'b0;
        m_words.delete();
      end else if (v) begin
        m_words.push_back(w);
        if (m_rep_n > 0 && w == m_rep_word) m_rep_n++;
        else begin
          m_rep_word = w;
          m_rep_n    = 1;
        end
        if (health_on && m_rep_n >= LIMIT) begin
          m_failed     = 1'b1;
          m_collecting = 1'b0;
          m_words.delete();
        end else if (m_words.size() == N) begin
          m_rdata = '0;
          foreach (m_words[i]) m_rdata = (m_rdata << TW) | OW'(m_words[i]);
          m_delivering = 1'b1;
          m_collecting = 1'b0;
          m_words.delete();
        end
      end
    end else if (r0 || r1) begin
      m_owner      = (r0 && r1) ? m_prio : r1;
      m_collecting = 1'b1;
      m_words.delete();
    end
  endtask

  task automatic checkOutput(input string tag, input logic [OW-1:0] observed,
                             input logic [OW-1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic checkAll(input string tag);
    string t;
    t = $sformatf("%s@%0d", tag, cyc);
    checkOutput({t, "_trng_req"}, OW'(bus.trng_req), OW'(m_collecting));
    checkOutput({t, "_ack0"}, OW'(bus.ack0), OW'(m_delivering && !m_owner));
    checkOutput({t, "_ack1"}, OW'(bus.ack1), OW'(m_delivering && m_owner));
    checkOutput({t, "_rdata"}, bus.rdata, m_rdata);
    checkOutput({t, "_health"}, OW'(bus.health_fail), OW'(m_failed));
    checkOutput({t, "_ack_excl"}, OW'(bus.ack0 & bus.ack1), '0);
  endtask

  task automatic applyStimulus(input bit r0, input bit r1, input bit v, input logic [TW-1:0] w);
    bus.req0       = r0;
    bus.req1       = r1;
    bus.trng_valid = v;
    bus.trng_word  = w;
    @(posedge clk);
    modelStep(r0, r1, v, w);
    #1;
    cyc++;
    if (bus.ack0) ack_order.push_back(0);
    if (bus.ack1) ack_order.push_back(1);
    checkAll("step");
  endtask

  task automatic doReset();
    bus.req0       = 1'b0;
    bus.req1       = 1'b0;
    bus.trng_valid = 1'b0;
    bus.trng_word  = '0;
    resetn         = 1'b0;
    modelReset();
    #2;
    checkAll("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [TW-1:0] wv;
    bit p0, p1, v;
`ifdef TRNG_HEALTH_EN
    health_on = 1'b1;
`else
    health_on = 1'b0;
`endif
    resetn = 1'b1;
    #3;
    doReset();

    // Single requester, valid held: word during the grant cycle is ignored
    applyStimulus(1, 0, 1, 8'hFF);
    checkOutput("r030_req_c1", OW'(bus.trng_req), OW'(1));
    applyStimulus(1, 0, 1, 8'hA1);
    applyStimulus(1, 0, 1, 8'hB2);
    applyStimulus(1, 0, 1, 8'hC3);
    checkOutput("r030_req_c4", OW'(bus.trng_req), OW'(1));
    applyStimulus(1, 0, 1, 8'hD4);
    checkOutput("r030_ack0", OW'(bus.ack0), OW'(1));
    checkOutput("r030_rdata", bus.rdata, 32'hA1B2C3D4);
    checkOutput("r030_req_c5", OW'(bus.trng_req), OW'(0));
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("r023_hold", bus.rdata, 32'hA1B2C3D4);
    checkOutput("r019_one_cycle", OW'(bus.ack0), OW'(0));

    // Gapped valid stream
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(1, 0, 1, 8'h11);
    applyStimulus(1, 0, 0, 8'hEE);
    applyStimulus(1, 0, 0, 8'hEE);
    applyStimulus(1, 0, 1, 8'h22);
    applyStimulus(1, 0, 1, 8'h33);
    checkOutput("r033_no_early_ack", OW'(bus.ack0), OW'(0));
    applyStimulus(1, 0, 0, 8'hEE);
    applyStimulus(1, 0, 1, 8'h44);
    checkOutput("r033_ack0", OW'(bus.ack0), OW'(1));
    checkOutput("r033_rdata", bus.rdata, 32'h11223344);
    applyStimulus(0, 0, 0, 8'h00);

    // Owner abandons mid-collection; next request gets only fresh words
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h31);
    applyStimulus(0, 1, 1, 8'h32);
    applyStimulus(0, 0, 1, 8'h33);
    checkOutput("r032_idle_req", OW'(bus.trng_req), OW'(0));
    checkOutput("r032_no_ack1", OW'(bus.ack1), OW'(0));
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(1, 0, 1, 8'h61);
    applyStimulus(1, 0, 1, 8'h62);
    applyStimulus(1, 0, 1, 8'h63);
    applyStimulus(1, 0, 1, 8'h64);
    checkOutput("r032_fresh", bus.rdata, 32'h61626364);
    applyStimulus(0, 0, 0, 8'h00);

    // Both requesters held: grants alternate starting with req0
    doReset();
    ack_order.delete();
    wv = 8'h80;
    for (int i = 0; i < 3 * (N + 2); i++) begin
      applyStimulus(1, 1, 1, wv);
      wv = wv + 8'd1;
    end
    checkOutput("r031_count", OW'(ack_order.size()), OW'(3));
    if (ack_order.size() == 3) begin
      checkOutput("r031_first", OW'(ack_order[0]), OW'(0));
      checkOutput("r031_second", OW'(ack_order[1]), OW'(1));
      checkOutput("r031_third", OW'(ack_order[2]), OW'(0));
    end

    // Reset in the middle of a collection
    doReset();
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(1, 0, 1, 8'h71);
    applyStimulus(1, 0, 1, 8'h72);
    applyStimulus(1, 0, 1, 8'h73);
    resetn = 1'b0;
    #1;
    modelReset();
    checkAll("r035_async");
    checkOutput("r035_req", OW'(bus.trng_req), OW'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(1, 0, 1, 8'h81);
    applyStimulus(1, 0, 1, 8'h82);
    applyStimulus(1, 0, 1, 8'h83);
    applyStimulus(1, 0, 1, 8'h84);
    checkOutput("r035_fresh", bus.rdata, 32'h81828384);
    applyStimulus(0, 0, 0, 8'h00);

    // Repeated words: health failure when enabled, plain delivery otherwise
    applyStimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < LIMIT; i++) applyStimulus(1, 0, 1, 8'h5A);
`ifdef TRNG_HEALTH_EN
    checkOutput("r034_fail", OW'(bus.health_fail), OW'(1));
    checkOutput("r034_no_ack", OW'(bus.ack0), OW'(0));
    checkOutput("r034_req_low", OW'(bus.trng_req), OW'(0));
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 8'h10 + TW'(i));
    checkOutput("r034_stuck_req", OW'(bus.trng_req), OW'(0));
    checkOutput("r034_sticky", OW'(bus.health_fail), OW'(1));
    doReset();
    checkOutput("r034_cleared", OW'(bus.health_fail), OW'(0));
`else
    checkOutput("r029_rdata", bus.rdata, 32'h5A5A5A5A);
    checkOutput("r029_ack0", OW'(bus.ack0), OW'(1));
    checkOutput("r029_no_fail", OW'(bus.health_fail), OW'(0));
    applyStimulus(0, 0, 0, 8'h00);
`endif

    // Randomized requesters and entropy stream
    doReset();
    p0 = 1'b0;
    p1 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!p0 && $urandom_range(0, 3) == 0) p0 = 1'b1;
      else if (p0 && $urandom_range(0, 40) == 0) p0 = 1'b0;
      if (!p1 && $urandom_range(0, 3) == 0) p1 = 1'b1;
      else if (p1 && $urandom_range(0, 40) == 0) p1 = 1'b0;
      v  = ($urandom_range(0, 9) < 7);
      wv = TW'($urandom);
      applyStimulus(p0, p1, v, wv);
      if (bus.ack0) p0 = 1'b0;
      if (bus.ack1) p1 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trng_arbiter.md
TRNG_ARBITER -- requirements
Module: trng_arbiter

Interface
REQ-001 Parameter TRNG_WIDTH, default 8, is the width of one entropy word from the TRNG source.
REQ-002 Parameter OUT_WIDTH, default 32, is the width of the assembled word delivered to a requester; it SHALL be an integer multiple of TRNG_WIDTH, with N = OUT_WIDTH/TRNG_WIDTH >= 2.
REQ-003 Parameter RCT_LIMIT, default 4, is the repetition-count limit used by the health test (see Configuration).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 trng_req  output  1  request to TRNG source, high while collecting.
REQ-007 trng_word  input  TRNG_WIDTH  entropy word, sampled only when trng_valid=1.
REQ-008 trng_valid  input  1  trng_word valid this cycle.
REQ-009 req0, req1  input  1 each  level requests; requester holds high until its ack.
REQ-010 ack0, ack1  output  1 each  one-cycle pulse; rdata valid in the same cycle.
REQ-011 rdata  output  OUT_WIDTH  assembled random word.
REQ-012 health_fail  output  1  sticky health-test failure flag.

Function
REQ-013 FSM states SHALL be IDLE, COLLECT, DELIVER and FAIL.
REQ-014 IDLE: if any reqX=1, latch the owner, clear the word counter and go to COLLECT next cycle; otherwise stay in IDLE.
REQ-015 Owner selection SHALL be round-robin: with both requests high, grant the requester not served last; after reset, req0 wins.
REQ-016 trng_req SHALL be 1 exactly while in COLLECT.
REQ-017 COLLECT: each cycle with trng_valid=1, shift the word in with rdata_next = {shift[OUT_WIDTH-TRNG_WIDTH-1:0], trng_word}, so the first word ends in the MSBs, and increment the counter.
REQ-018 The Nth accepted word SHALL move the FSM to DELIVER; the counter is ceil(log2 N) bits and never wraps.
REQ-019 DELIVER: assert ack of the owner only, for exactly one cycle, with rdata stable; flip the round-robin pointer; return to IDLE.
REQ-020 Latency: with trng_valid held at 1, a request seen in IDLE at cycle 0 SHALL be acked at cycle N+1.
REQ-021 If the owner drops its request during COLLECT, discard partial data, issue no ack, leave the pointer unchanged and return to IDLE.
REQ-022 trng_valid outside COLLECT SHALL be ignored; the non-owner's request is ignored until the FSM is back in IDLE.
REQ-023 rdata SHALL hold its last delivered value outside DELIVER; the shift register is internal and not visible until DELIVER.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-025 While resetn=0: state=IDLE, trng_req=0, ack0=ack1=0, rdata=0, counter=0, pointer favours req0, health_fail=0, repetition counter=0.
REQ-026 Reset asserted mid-COLLECT SHALL discard partial data immediately (asynchronously), with no ack.

Configuration
REQ-027 Macro TRNG_HEALTH_EN SHALL control the repetition-count health test.
REQ-028 With TRNG_HEALTH_EN defined: count consecutive identical accepted trng_words across requests. On reaching RCT_LIMIT identical words, health_fail=1 the next cycle and the FSM enters FAIL. In FAIL, trng_req=0 and no acks are issued, and the current collection is discarded. Only reset exits FAIL.
REQ-029 Without TRNG_HEALTH_EN: health_fail is tied to 0, FAIL is unreachable and no comparison logic is built.

Verification
REQ-030 req0=1, trng_valid=1 with words 0xA1, 0xB2, 0xC3, 0xD4 -> ack0 pulses at cycle 5 with rdata=0xA1B2C3D4; trng_req is high during cycles 1-4.
REQ-031 req0=req1=1 held continuously after reset -> acks alternate ack0, ack1, ack0; never both high.
REQ-032 req1 enters COLLECT, 2 words accepted, then req1 drops -> no ack, FSM returns to IDLE; next req0 delivers only fresh words.
REQ-033 trng_valid toggling 1,0,0,1,1,0,1 with words 0x11, 0x22, 0x33, 0x44 -> ack arrives one cycle after the 4th valid word, with rdata=0x11223344.
REQ-034 TRNG_HEALTH_EN defined, 4 consecutive words of 0x5A -> health_fail=1, no ack, trng_req=0 and stays 0 despite requests; resetn pulse clears it.
REQ-035 resetn asserted after 3 words in COLLECT -> all outputs at reset values; after release, a new request yields a full fresh 4-word result.
